// File: rtl/pp_pkg.sv
// Shared defaults and state encoding for the
// partial-product accumulator.
package pp_pkg;

  localparam int PP_W_DEFAULT   = 8;
  localparam int NUM_PP_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pp_accumulator.sv
// Sequential partial-product accumulator: latches a set,
// sums it one term per cycle, and holds the result until taken.
module pp_accumulator
  import pp_pkg::*;
#(
  parameter int PP_W   = PP_W_DEFAULT,
  parameter int NUM_PP = NUM_PP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_PP*PP_W-1:0] pp_bus,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PP_W-1:0]        product,
  output logic                   busy
);

  localparam int IDX_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PP - 1);

  state_t                 state;
  logic [NUM_PP*PP_W-1:0] pp_q;
  logic [PP_W-1:0]        acc;
  logic [PP_W-1:0]        pp_sel;
  logic [IDX_W-1:0]       idx;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign product  = acc;
  assign pp_sel   = pp_q[int'(idx)*PP_W +: PP_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pp_q      <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            pp_q  <= pp_bus;
            acc   <= '0;
            idx   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc + pp_sel;
          // idx parks on the last term so it never wraps
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench for pp_accumulator with a
// behavioural sum model and randomized stimulus.
module tb_pp_accumulator;

  localparam int PP_W   = 8;
  localparam int NUM_PP = 4;
  localparam int BUS_W  = PP_W * NUM_PP;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] pp_bus;
  logic             out_valid;
  logic             out_ready;
  logic [PP_W-1:0]  product;
  logic             busy;

  int errors = 0;
  int checks = 0;

  pp_accumulator #(
    .PP_W  (PP_W),
    .NUM_PP(NUM_PP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pp_bus   (pp_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed sum of all terms, reduced modulo 2^PP_W
  function automatic logic [PP_W-1:0] model_sum(input logic [BUS_W-1:0] b);
    int s;
    logic [PP_W-1:0] t;
    s = 0;
    for (int i = 0; i < NUM_PP; i++) begin
      t = b[i*PP_W +: PP_W];
      s += int'($signed(t));
    end
    return PP_W'(s);
  endfunction

  function automatic logic [BUS_W-1:0] pack4(input logic [7:0] p0,
      input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  // Accept one set and wait (bounded) for out_valid; lat=-1 on timeout
  task automatic run_op(input logic [BUS_W-1:0] bus,
                        output int lat, output logic [PP_W-1:0] prod);
    int n;
    in_valid = 1'b1;
    pp_bus   = bus;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    lat  = out_valid ? n : -1;
    prod = product;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pp_bus = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || product !== 8'h00 || busy !== 1'b0
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: ov=%b prod=%h busy=%b rdy=%b want 0 00 0 1",
               out_valid, product, busy, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_booth();
    int lat; logic [PP_W-1:0] p;
    logic [BUS_W-1:0] b;
    b = pack4(8'hFD, 8'h06, 8'hF4, 8'h18);
    run_op(b, lat, p);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL booth_latency: got %0d want 4", lat);
    end
    checks++;
    if (p !== 8'h0F) begin
      errors++; $display("FAIL booth_product: got %h want 0f", p);
    end
    release_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL booth_return: rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [PP_W-1:0] p;
    run_op(pack4(8'h00, 8'h00, 8'h00, 8'h40), lat, p);
    checks++;
    if (p !== 8'h40 || lat !== 4) begin
      errors++; $display("FAIL last_term: got %h lat %0d want 40 lat 4", p, lat);
    end
    release_op();
    run_op(pack4(8'h7F, 8'h7F, 8'h7F, 8'h7F), lat, p);
    checks++;
    if (p !== 8'hFC) begin
      errors++; $display("FAIL wrap: got %h want fc", p);
    end
    release_op();
  endtask

  task automatic test_hold();
    int lat; logic [PP_W-1:0] p;
    logic [BUS_W-1:0] b;
    int bad;
    b = $urandom;
    run_op(b, lat, p);
    checks++;
    if (p !== model_sum(b)) begin
      errors++; $display("FAIL hold_product: got %h want %h", p, model_sum(b));
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      pp_bus = $urandom;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || product !== p || in_ready !== 1'b0
          || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
    end
    release_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: rdy=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_pp_change();
    logic [BUS_W-1:0] b;
    int n;
    b = $urandom;
    in_valid = 1'b1;
    pp_bus = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      pp_bus = $urandom;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n++;
    end
    checks++;
    if (n !== 4 || product !== model_sum(b)) begin
      errors++;
      $display("FAIL pp_change: got %h lat %0d want %h lat 4",
               product, n, model_sum(b));
    end
    release_op();
  endtask

  task automatic test_async_reset();
    int lat; logic [PP_W-1:0] p;
    in_valid = 1'b1;
    pp_bus = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || product !== 8'h00 || busy !== 1'b0
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ov=%b prod=%h busy=%b rdy=%b want 0 00 0 1",
               out_valid, product, busy, in_ready);
    end
    #1;
    rst_n = 1'b1;
    run_op(pack4(8'hFD, 8'h06, 8'hF4, 8'h18), lat, p);
    checks++;
    if (p !== 8'h0F || lat !== 4) begin
      errors++;
      $display("FAIL after_reset: got %h lat %0d want 0f lat 4", p, lat);
    end
    release_op();
  endtask

  // With in_valid and out_ready held high the pipeline cycles every
  // NUM_PP+2 cycles: one IDLE, NUM_PP in ACC, one in DONE.
  task automatic test_back_to_back();
    localparam int PER = NUM_PP + 2;
    logic [BUS_W-1:0] cap;
    int bad_rdy, bad_ov, bad_prod;
    bad_rdy = 0; bad_ov = 0; bad_prod = 0;
    cap = '0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5 * PER; i++) begin
      pp_bus = $urandom;
      if (in_ready !== ((i % PER) == 0)) bad_rdy++;
      if (out_valid !== ((i % PER) == PER - 1)) bad_ov++;
      if ((i % PER) == 0) cap = pp_bus;
      if ((i % PER) == PER - 1 && product !== model_sum(cap)) bad_prod++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (bad_rdy != 0) begin
      errors++; $display("FAIL b2b_accept: %0d bad in_ready cycles, want 0", bad_rdy);
    end
    checks++;
    if (bad_ov != 0) begin
      errors++; $display("FAIL b2b_valid: %0d bad out_valid cycles, want 0", bad_ov);
    end
    checks++;
    if (bad_prod != 0) begin
      errors++; $display("FAIL b2b_product: %0d bad products, want 0", bad_prod);
    end
  endtask

  task automatic test_random();
    int lat; logic [PP_W-1:0] p;
    logic [BUS_W-1:0] b;
    int d;
    for (int k = 0; k < 20; k++) begin
      d = 0;
      while (!in_ready && d < 10) begin
        @(posedge clk); #1; d++;
      end
      b = {$urandom};
      run_op(b, lat, p);
      checks++;
      if (p !== model_sum(b) || lat !== 4) begin
        errors++;
        $display("FAIL random_%0d: got %h lat %0d want %h lat 4",
                 k, p, lat, model_sum(b));
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      release_op();
    end
  endtask

  initial begin
    test_reset();
    test_booth();
    test_wrap();
    test_hold();
    test_pp_change();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pp_accumulator.md
PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 SHALL have parameter PP_W, default 8, partial-product and result width in bits.
REQ-002 SHALL have parameter NUM_PP, default 4, number of partial products per operation.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream presents a full partial-product set.
REQ-006 SHALL have port in_ready, output, 1, block can accept a set this cycle.
REQ-007 SHALL have port pp_bus, input, NUM_PP*PP_W, packed signed partial products; pp[i] occupies bits [i*PP_W +: PP_W].
REQ-008 SHALL have port out_valid, output, 1, product is valid.
REQ-009 SHALL have port out_ready, input, 1, downstream takes the product.
REQ-010 SHALL have port product, output, PP_W, signed sum of the captured partial products.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement three states: IDLE, ACC, DONE.
REQ-013 SHALL drive in_ready high only in IDLE, combinationally from state.
REQ-014 SHALL treat an input transfer as accepted on a rising edge where in_valid and in_ready are both high.
REQ-015 On acceptance, SHALL latch all of pp_bus into an internal register, clear the accumulator to 0, clear index counter to 0, and enter ACC.
REQ-016 SHALL ignore pp_bus changes after acceptance; only latched values are summed.
REQ-017 In ACC, SHALL add latched pp[index] to the accumulator each edge and increment index, adding pp[0] first and pp[NUM_PP-1] last.
REQ-018 SHALL add in two's complement modulo 2^PP_W; overflow wraps silently with no flag.
REQ-019 On the edge adding pp[NUM_PP-1], SHALL enter DONE and assert out_valid.
REQ-020 Latency SHALL be exactly NUM_PP cycles: acceptance at edge k, out_valid high after edge k+NUM_PP.
REQ-021 product SHALL equal the accumulator register at all times; it SHALL be stable while out_valid is high.
REQ-022 In DONE, SHALL hold out_valid and product until an edge with out_ready high, then deassert out_valid and return to IDLE.
REQ-023 SHALL NOT accept new input in DONE even if out_ready is high that cycle; the next acceptance occurs no earlier than the cycle after returning to IDLE.
REQ-024 out_ready while not in DONE SHALL have no effect.
REQ-025 The index counter SHALL be ceil(log2(NUM_PP)) bits wide, minimum 1, and SHALL NOT wrap within an operation.

Reset
REQ-026 Assertion of rst_n low SHALL immediately force IDLE, out_valid=0, product=0, index=0, latched partial products=0, busy=0, and in_ready=1, including mid-ACC or mid-DONE; the in-flight operation is discarded.
REQ-027 After rst_n deasserts, SHALL accept input on the first qualifying edge.

Structure
REQ-028 Shared package pp_pkg SHALL hold the PP_W/NUM_PP defaults and the state enumeration type.
REQ-029 SHALL be a single module with no sub-module; the partial-product select is an indexed mux inside it.

Verification
REQ-030 Default parameters; pp_bus pp0..pp3 = 0xFD,0x06,0xF4,0x18 (Booth set for 3*5) -> product=0x0F, out_valid rises exactly 4 cycles after acceptance.
REQ-031 pp3=0x40, others 0 -> product=0x40; then pp0..pp3 all 0x7F -> product=0xFC, confirming wrap.
REQ-032 Hold out_ready low 10 cycles in DONE -> out_valid and product stable, in_ready low; raise out_ready -> IDLE next edge, in_ready high.
REQ-033 Change pp_bus every cycle during ACC -> product reflects only the values present at acceptance.
REQ-034 Assert rst_n low during ACC cycle 2 -> outputs reach reset values without a clock edge; after release, a new set 0xFD,0x06,0xF4,0x18 yields 0x0F.
REQ-035 in_valid held high continuously with out_ready high -> one acceptance per NUM_PP+2 cycles, with no acceptance during ACC or DONE.
